decode_pipe: RTL and testbench

Parametrised decode stage with integrated 2R1W register file, write-back bypass, ID/EX pipeline register with valid/ready handshake, flush, load-use bubble insertion and a saturating hazard counter. It sits between the fetch pipeline register and the execute stage. It consumes already-decoded control and immediate from the control unit and extend unit. It is the next generation of the fixed 32-bit decode stage.

---
 rtl/decode_pipe.sv | 125 ++++++++++++
 tb/tb_decode_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// Decode stage: 2R1W register file with write-back bypass, ID/EX pipeline register
// with valid/ready handshake, flush, load-use bubble insertion and saturating hazard counter.
module decode_pipe #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              valid_d,
   output logic              ready_d,
   input  logic [XLEN-1:0]   pc_d,
   input  logic [XLEN-1:0]   pc_plus4_d,
   input  logic [XLEN-1:0]   imm_ext_d,
   input  logic [AW-1:0]     rs1_d,
   input  logic [AW-1:0]     rs2_d,
   input  logic [AW-1:0]     rd_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic              reg_write_d,
   input  logic              load_d,
   input  logic              reg_write_w,
   input  logic [AW-1:0]     rd_w,
   input  logic [XLEN-1:0]   result_w,
   input  logic              ready_e,
   input  logic              flush_e,
   output logic              valid_e,
   output logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   pc_plus4_e,
   output logic [XLEN-1:0]   imm_ext_e,
   output logic [XLEN-1:0]   rd1_e,
   output logic [XLEN-1:0]   rd2_e,
   output logic [AW-1:0]     rs1_e,
   output logic [AW-1:0]     rs2_e,
   output logic [AW-1:0]     rd_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic              reg_write_e,
   output logic              load_e,
   output logic              load_use_stall,
   output logic [CNT_W-1:0]  hazard_cnt
);

   logic [XLEN-1:0] rf [NREG];
   logic [XLEN-1:0] rd1_d, rd2_d;
   logic            wb_hit, hazard, adv;

   assign wb_hit = reg_write_w && (rd_w != '0);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_hit) begin
         rf[rd_w] <= result_w;
      end
   end

   // x0 is forced to zero on read; a same-cycle write-back wins over the array
   always_comb begin
      rd1_d = '0;
      rd2_d = '0;
      if (rs1_d != '0) rd1_d = (wb_hit && rd_w == rs1_d) ? result_w : rf[rs1_d];
      if (rs2_d != '0) rd2_d = (wb_hit && rd_w == rs2_d) ? result_w : rf[rs2_d];
   end

   assign hazard = valid_d && valid_e && load_e && (rd_e != '0) &&
                   ((rs1_d == rd_e) || (rs2_d == rd_e));
   assign load_use_stall = hazard;
   assign adv     = !valid_e || ready_e;
   assign ready_d = adv && !hazard && !flush_e;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         valid_e     <= 1'b0;
         pc_e        <= '0;
         pc_plus4_e  <= '0;
         imm_ext_e   <= '0;
         rd1_e       <= '0;
         rd2_e       <= '0;
         rs1_e       <= '0;
         rs2_e       <= '0;
         rd_e        <= '0;
         ctrl_e      <= '0;
         reg_write_e <= 1'b0;
         load_e      <= 1'b0;
      end else if (flush_e || (adv && hazard)) begin
         // kill or bubble: payload is left as-is, only valid and control clear
         valid_e     <= 1'b0;
         ctrl_e      <= '0;
         reg_write_e <= 1'b0;
         load_e      <= 1'b0;
      end else if (adv) begin
         valid_e <= valid_d;
         if (valid_d) begin
            pc_e        <= pc_d;
            pc_plus4_e  <= pc_plus4_d;
            imm_ext_e   <= imm_ext_d;
            rd1_e       <= rd1_d;
            rd2_e       <= rd2_d;
            rs1_e       <= rs1_d;
            rs2_e       <= rs2_d;
            rd_e        <= rd_d;
            ctrl_e      <= ctrl_d;
            reg_write_e <= reg_write_d;
            load_e      <= load_d;
         end else begin
            ctrl_e      <= '0;
            reg_write_e <= 1'b0;
            load_e      <= 1'b0;
         end
      end else begin
         // stalled by execute: keep operands coherent with write-back
         if (wb_hit && rd_w == rs1_e) rd1_e <= result_w;
         if (wb_hit && rd_w == rs2_e) rd2_e <= result_w;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         hazard_cnt <= '0;
      else if (adv && hazard && !flush_e && hazard_cnt != '1)
         hazard_cnt <= hazard_cnt + 1'b1;
   end

endmodule

// File: tb/tb_decode_pipe.sv
// Randomized bench for decode_pipe against a behavioural model, plus directed scenarios;
// a second instance with a 2-bit counter covers saturation on the same stimulus.
module tb_decode_pipe;
   localparam int XLEN = 32, NREG = 32, CTRL_W = 12, CNT_W = 16, AW = 5;

   logic clk = 1'b0, arst_n = 1'b0;
   always #5 clk = ~clk;

   logic              valid_d = 0, reg_write_d = 0, load_d = 0, reg_write_w = 0;
   logic              ready_e = 0, flush_e = 0;
   logic [XLEN-1:0]   pc_d = 0, pc_plus4_d = 0, imm_ext_d = 0, result_w = 0;
   logic [AW-1:0]     rs1_d = 0, rs2_d = 0, rd_d = 0, rd_w = 0;
   logic [CTRL_W-1:0] ctrl_d = 0;

   logic              ready_d, valid_e, reg_write_e, load_e, load_use_stall;
   logic [XLEN-1:0]   pc_e, pc_plus4_e, imm_ext_e, rd1_e, rd2_e;
   logic [AW-1:0]     rs1_e, rs2_e, rd_e;
   logic [CTRL_W-1:0] ctrl_e;
   logic [CNT_W-1:0]  hazard_cnt;

   logic              s_ready_d, s_valid_e, s_reg_write_e, s_load_e, s_stall;
   logic [XLEN-1:0]   s_pc_e, s_pc4_e, s_imm_e, s_rd1_e, s_rd2_e;
   logic [AW-1:0]     s_rs1_e, s_rs2_e, s_rd_e;
   logic [CTRL_W-1:0] s_ctrl_e;
   logic [1:0]        s_cnt;

   decode_pipe #(.XLEN(XLEN), .NREG(NREG), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst_n(arst_n), .valid_d(valid_d), .ready_d(ready_d),
      .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .ctrl_d(ctrl_d),
      .reg_write_d(reg_write_d), .load_d(load_d),
      .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
      .ready_e(ready_e), .flush_e(flush_e), .valid_e(valid_e),
      .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .imm_ext_e(imm_ext_e),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .ctrl_e(ctrl_e), .reg_write_e(reg_write_e), .load_e(load_e),
      .load_use_stall(load_use_stall), .hazard_cnt(hazard_cnt));

   decode_pipe #(.XLEN(XLEN), .NREG(NREG), .CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
      .clk(clk), .arst_n(arst_n), .valid_d(valid_d), .ready_d(s_ready_d),
      .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .ctrl_d(ctrl_d),
      .reg_write_d(reg_write_d), .load_d(load_d),
      .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
      .ready_e(ready_e), .flush_e(flush_e), .valid_e(s_valid_e),
      .pc_e(s_pc_e), .pc_plus4_e(s_pc4_e), .imm_ext_e(s_imm_e),
      .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e),
      .ctrl_e(s_ctrl_e), .reg_write_e(s_reg_write_e), .load_e(s_load_e),
      .load_use_stall(s_stall), .hazard_cnt(s_cnt));

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
      end
   endtask

   // reference model state: EX register contents as plain variables, register file as array
   logic              m_v, m_rw, m_ld;
   logic [XLEN-1:0]   m_pc, m_pc4, m_imm, m_rd1, m_rd2;
   logic [AW-1:0]     m_rs1, m_rs2, m_rd;
   logic [CTRL_W-1:0] m_ctrl;
   logic [XLEN-1:0]   m_rf [NREG];
   int                m_cnt;

   task automatic model_reset();
      m_v = 0; m_rw = 0; m_ld = 0; m_ctrl = 0; m_cnt = 0;
      m_pc = 0; m_pc4 = 0; m_imm = 0; m_rd1 = 0; m_rd2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      for (int i = 0; i < NREG; i++) m_rf[i] = 0;
   endtask

   function automatic logic [XLEN-1:0] mread(input logic [AW-1:0] a);
      if (a == 0) return 0;
      if (reg_write_w && rd_w == a) return result_w;
      return m_rf[a];
   endfunction

   function automatic logic m_hazard();
      return valid_d && m_v && m_ld && m_rd != 0 && (rs1_d == m_rd || rs2_d == m_rd);
   endfunction

   task automatic check_ex();
      chk("valid_e", valid_e, m_v);
      chk("ctrl_e", ctrl_e, m_ctrl);
      chk("reg_write_e", reg_write_e, m_rw);
      chk("load_e", load_e, m_ld);
      chk("hazard_cnt", hazard_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("sat_cnt", s_cnt, (m_cnt > 3) ? 3 : m_cnt);
      if (m_v) begin
         chk("pc_e", pc_e, m_pc);
         chk("pc_plus4_e", pc_plus4_e, m_pc4);
         chk("imm_ext_e", imm_ext_e, m_imm);
         chk("rd1_e", rd1_e, m_rd1);
         chk("rd2_e", rd2_e, m_rd2);
         chk("rs1_e", rs1_e, m_rs1);
         chk("rs2_e", rs2_e, m_rs2);
         chk("rd_e", rd_e, m_rd);
      end
   endtask

   // one clock with the currently driven inputs: check comb outputs, advance model, check EX
   task automatic step();
      logic hz, adv;
      logic [XLEN-1:0] r1, r2;
      #1;
      hz  = m_hazard();
      adv = !m_v || ready_e;
      chk("ready_d", ready_d, adv && !hz && !flush_e);
      chk("load_use_stall", load_use_stall, hz);
      r1 = mread(rs1_d);
      r2 = mread(rs2_d);
      @(posedge clk);
      if (flush_e || (adv && hz)) begin
         if (!flush_e) m_cnt++;
         m_v = 0; m_ctrl = 0; m_rw = 0; m_ld = 0;
      end else if (adv) begin
         m_v = valid_d;
         if (valid_d) begin
            m_pc = pc_d; m_pc4 = pc_plus4_d; m_imm = imm_ext_d; m_rd1 = r1; m_rd2 = r2;
            m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
            m_ctrl = ctrl_d; m_rw = reg_write_d; m_ld = load_d;
         end else begin
            m_ctrl = 0; m_rw = 0; m_ld = 0;
         end
      end else if (reg_write_w && rd_w != 0) begin
         if (rd_w == m_rs1) m_rd1 = result_w;
         if (rd_w == m_rs2) m_rd2 = result_w;
      end
      if (reg_write_w && rd_w != 0) m_rf[rd_w] = result_w;
      #1;
      check_ex();
   endtask

   task automatic rst_chk();
      chk("rst_valid_e", valid_e, 0);     chk("rst_pc_e", pc_e, 0);
      chk("rst_pc4_e", pc_plus4_e, 0);    chk("rst_imm_e", imm_ext_e, 0);
      chk("rst_rd1_e", rd1_e, 0);         chk("rst_rd2_e", rd2_e, 0);
      chk("rst_rs1_e", rs1_e, 0);         chk("rst_rs2_e", rs2_e, 0);
      chk("rst_rd_e", rd_e, 0);           chk("rst_ctrl_e", ctrl_e, 0);
      chk("rst_reg_write_e", reg_write_e, 0); chk("rst_load_e", load_e, 0);
      chk("rst_hazard_cnt", hazard_cnt, 0);   chk("rst_sat_cnt", s_cnt, 0);
   endtask

   // asynchronous reset applied between edges
   task automatic do_reset();
      @(negedge clk);
      #2 arst_n = 0;
      #1 model_reset();
      rst_chk();
      @(negedge clk);
      arst_n = 1;
   endtask

   task automatic decode(input logic [AW-1:0] a1, a2, d, input logic ld, rw);
      valid_d = 1; rs1_d = a1; rs2_d = a2; rd_d = d; load_d = ld; reg_write_d = rw;
      pc_d = $urandom; pc_plus4_d = pc_d + 4; imm_ext_d = $urandom; ctrl_d = 12'(($urandom % 4095) + 1);
   endtask

   int base;

   initial begin
      model_reset();
      #3 rst_chk();
      @(negedge clk);
      arst_n = 1;

      // bypass: WB x3 in the same cycle decode reads rs1=3
      ready_e = 1;
      decode(3, 0, 1, 0, 1);
      reg_write_w = 1; rd_w = 3; result_w = 32'hDEADBEEF;
      step();
      chk("byp_rd1", rd1_e, 32'hDEADBEEF);
      chk("byp_rd2", rd2_e, 0);
      valid_d = 0; rd_w = 0; result_w = 32'h1234;
      step();
      reg_write_w = 0;
      decode(0, 0, 2, 0, 1);
      step();
      chk("x0_read", rd1_e, 0);

      // load-use on rs2
      decode(1, 2, 7, 1, 1);
      step();
      decode(1, 7, 8, 0, 1);
      #1 chk("lu_stall", load_use_stall, 1);
      chk("lu_ready_d", ready_d, 0);
      step();
      chk("lu_bubble", valid_e, 0);
      chk("lu_cnt", hazard_cnt, 1);
      step();
      chk("lu_accept", valid_e, 1);
      chk("lu_rs2_e", rs2_e, 7);

      // backpressure with operand refresh
      decode(4, 0, 9, 0, 1);
      reg_write_w = 1; rd_w = 4; result_w = 32'h10;
      step();
      chk("bp_cap", rd1_e, 32'h10);
      valid_d = 0; ready_e = 0; reg_write_w = 0;
      step();
      reg_write_w = 1; rd_w = 4; result_w = 32'h99;
      step();
      chk("bp_refresh", rd1_e, 32'h99);
      reg_write_w = 0;
      step();
      chk("bp_hold_rs1", rs1_e, 4);
      chk("bp_hold_rd", rd_e, 9);
      ready_e = 1;
      step();

      // flush beats hazard
      decode(1, 2, 6, 1, 1);
      step();
      base = m_cnt;
      decode(6, 0, 3, 0, 1);
      flush_e = 1;
      #1 chk("fl_ready_d", ready_d, 0);
      step();
      chk("fl_valid", valid_e, 0);
      chk("fl_ctrl", ctrl_e, 0);
      chk("fl_cnt", hazard_cnt, base);
      flush_e = 0;

      // mid-stream reset with valid_e=1, then x5 reads zero
      decode(0, 0, 5, 0, 1);
      reg_write_w = 1; rd_w = 5; result_w = 32'h55;
      step();
      reg_write_w = 0;
      step();
      chk("pre_rst_valid", valid_e, 1);
      do_reset();
      decode(5, 5, 1, 0, 0);
      step();
      chk("x5_after_rst", rd1_e, 0);

      // five load-use hazards: 2-bit counter must pin at 3
      for (int k = 0; k < 5; k++) begin
         decode(1, 2, 10, 1, 1);
         step();
         decode(10, 3, 11, 0, 1);
         step();
      end
      chk("sat_3", s_cnt, 3);
      chk("wide_5", hazard_cnt, 5);
      valid_d = 0;
      step();
      chk("sat_hold", s_cnt, 3);

      // randomized traffic over a small register window to provoke hazards and bypass
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         decode(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
         valid_d     = $urandom_range(0, 3) != 0;
         ready_e     = $urandom_range(0, 9) < 7;
         flush_e     = $urandom_range(0, 9) == 0;
         reg_write_w = $urandom_range(0, 1);
         rd_w        = AW'($urandom_range(0, 7));
         result_w    = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
